// File: rtl/addsub_bist_pkg.sv
// -----------------------------------------------------------------------------
// addsub_bist_pkg
// Shared types and helpers for the add/subtract BIST controller.
//   state_t      : controller FSM states
//   DEFAULT_WIDTH: default operand width of the adder under test
//   addsub_ovf() : signed-overflow rule for a two's-complement add/subtract
// -----------------------------------------------------------------------------
package addsub_bist_pkg;

  localparam int DEFAULT_WIDTH = 4;

  typedef enum logic [1:0] {
    IDLE,
    DRIVE,
    SAMPLE,
    DONE
  } state_t;

  // Overflow only depends on the sign bits: an add overflows when both operands
  // share a sign that the result lost; a subtract overflows when the operands
  // differ in sign and the result does not keep the sign of a.
  function automatic logic addsub_ovf(input logic a_msb,
                                      input logic b_msb,
                                      input logic sel,
                                      input logic r_msb);
    if (sel) return (a_msb != b_msb) && (r_msb != a_msb);
    return (a_msb == b_msb) && (r_msb != a_msb);
  endfunction

endpackage : addsub_bist_pkg

// File: rtl/addsub_bist_golden.sv
// -----------------------------------------------------------------------------
// addsub_golden
// Combinational reference adder/subtractor used by the BIST controller.
// Ports:
//   a_i, b_i        operands
//   sel_i           0 = add, 1 = subtract
//   exp_result_o    expected sum/difference, modulo 2^WIDTH
//   exp_overflow_o  expected signed overflow flag
// -----------------------------------------------------------------------------
module addsub_golden
  import addsub_bist_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             sel_i,
  output logic [WIDTH-1:0] exp_result_o,
  output logic             exp_overflow_o
);

  // Subtract is a + ~b + 1; the sum wraps naturally at WIDTH bits.
  assign exp_result_o   = a_i + (b_i ^ {WIDTH{sel_i}}) + WIDTH'(sel_i);
  assign exp_overflow_o = addsub_ovf(a_i[WIDTH-1], b_i[WIDTH-1], sel_i,
                                     exp_result_o[WIDTH-1]);

endmodule : addsub_golden

// File: rtl/addsub_bist_ctrl.sv
// -----------------------------------------------------------------------------
// addsub_bist_ctrl
// Built-in self-test controller for a WIDTH-bit adder/subtractor. Sweeps every
// {sel,a,b} vector, holds each for SETTLE_CYCLES cycles, samples the DUT in
// the following cycle and counts mismatches against addsub_golden.
// Ports:
//   clk, rst              clock (rising edge), asynchronous active-high reset
//   start_i               launch a sweep (honoured only in IDLE or DONE)
//   dut_a_o/b_o/sel_o     registered operands and operation to the DUT
//   dut_result_i          DUT sum/difference
//   dut_overflow_i        DUT signed overflow flag
//   busy_o                sweep in progress
//   done_o                sweep complete, held until next accepted start/reset
//   pass_o                done with zero mismatches
//   err_count_o           mismatching vectors, saturating
//   fail_vec_o            {sel,a,b} of the first failing vector
//   fail_valid_o          fail_vec_o holds a capture
// Build option: define ADDSUB_BIST_FAIL_CAPTURE_EN to enable first-failure
// capture; without it fail_vec_o/fail_valid_o are constant 0.
// -----------------------------------------------------------------------------
module addsub_bist_ctrl
  import addsub_bist_pkg::*;
#(
  parameter int WIDTH         = DEFAULT_WIDTH,
  parameter int SETTLE_CYCLES = 1,
  parameter int ERR_W         = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start_i,
  output logic [WIDTH-1:0]   dut_a_o,
  output logic [WIDTH-1:0]   dut_b_o,
  output logic               dut_sel_o,
  input  logic [WIDTH-1:0]   dut_result_i,
  input  logic               dut_overflow_i,
  output logic               busy_o,
  output logic               done_o,
  output logic               pass_o,
  output logic [ERR_W-1:0]   err_count_o,
  output logic [2*WIDTH:0]   fail_vec_o,
  output logic               fail_valid_o
);

  localparam int IDX_W = 2 * WIDTH + 1;
  localparam int SET_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [SET_W-1:0] SETTLE_LAST = SET_W'(SETTLE_CYCLES - 1);

  state_t           state_q;
  // The vector index doubles as the operand register: operands only move when
  // the index moves, so one register serves both.
  logic [IDX_W-1:0] idx_q;
  logic [IDX_W-1:0] idx_d;
  logic [SET_W-1:0] settle_q;
  logic [ERR_W-1:0] err_q;
  logic [ERR_W-1:0] err_d;
  logic             busy_q;
  logic             done_q;
  logic             pass_q;

  logic [WIDTH-1:0] exp_result;
  logic             exp_overflow;
  logic             mismatch;

  addsub_golden #(.WIDTH(WIDTH)) u_golden (
    .a_i            (dut_a_o),
    .b_i            (dut_b_o),
    .sel_i          (dut_sel_o),
    .exp_result_o   (exp_result),
    .exp_overflow_o (exp_overflow)
  );

  assign mismatch = (dut_result_i != exp_result) || (dut_overflow_i != exp_overflow);
  assign idx_d    = idx_q + IDX_W'(1);

  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    err_d = err_q;
    if (state_q == SAMPLE && mismatch && err_q != '1) err_d = err_q + ERR_W'(1);
  end

  // NOTE: state uses non-blocking assignments so every register updates from
  // the pre-edge values, independent of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      idx_q    <= '0;
      settle_q <= '0;
      err_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      pass_q   <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE, DONE: begin
          if (start_i) begin
            state_q  <= DRIVE;
            idx_q    <= '0;
            settle_q <= '0;
            err_q    <= '0;
            busy_q   <= 1'b1;
            done_q   <= 1'b0;
            pass_q   <= 1'b0;
          end
        end
        DRIVE: begin
          if (settle_q == SETTLE_LAST) begin
            state_q  <= SAMPLE;
            settle_q <= '0;
          end else begin
            settle_q <= settle_q + SET_W'(1);
          end
        end
        SAMPLE: begin
          err_q <= err_d;
          if (idx_q == '1) begin
            state_q <= DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            pass_q  <= (err_d == '0);
          end else begin
            state_q <= DRIVE;
            idx_q   <= idx_d;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign {dut_sel_o, dut_a_o, dut_b_o} = idx_q;
  assign busy_o      = busy_q;
  assign done_o      = done_q;
  assign pass_o      = pass_q;
  assign err_count_o = err_q;

`ifdef ADDSUB_BIST_FAIL_CAPTURE_EN
  logic             accept;
  logic [IDX_W-1:0] fail_vec_q;
  logic             fail_valid_q;

  assign accept = start_i && (state_q == IDLE || state_q == DONE);

  // Only the first mismatch of a sweep is kept; later ones are ignored.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fail_vec_q   <= '0;
      fail_valid_q <= 1'b0;
    end else if (accept) begin
      fail_vec_q   <= '0;
      fail_valid_q <= 1'b0;
    end else if (state_q == SAMPLE && mismatch && !fail_valid_q) begin
      fail_vec_q   <= idx_q;
      fail_valid_q <= 1'b1;
    end
  end

  assign fail_vec_o   = fail_vec_q;
  assign fail_valid_o = fail_valid_q;
`else
  assign fail_vec_o   = '0;
  assign fail_valid_o = 1'b0;
`endif

endmodule : addsub_bist_ctrl

// File: tb/tb_addsub_bist_ctrl.sv
// -----------------------------------------------------------------------------
// tb_addsub_bist_ctrl
// Self-checking bench for addsub_bist_ctrl (WIDTH=4, SETTLE_CYCLES=1). A
// behavioural 4-bit adder/subtractor with selectable faults sits on the
// controller's operand side. A second controller with an 8-bit error counter
// runs in lockstep to exercise counter saturation.
// -----------------------------------------------------------------------------
module tb_addsub_bist_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;

  logic [3:0] dut_a, dut_b, dut_result;
  logic       dut_sel, dut_overflow;
  logic       busy, done, pass;
  logic [15:0] err_count;
  logic [8:0] fail_vec;
  logic       fail_valid;

  logic [3:0] s_a, s_b, s_result;
  logic       s_sel, s_overflow;
  logic       s_busy, s_done, s_pass;
  logic [7:0] s_err_count;
  logic [8:0] s_fail_vec;
  logic       s_fail_valid;

  // Fault selection: 0 none, 1 overflow tied 0, 2 result[0] stuck-at-0,
  // 3 result inverted, 4 flip result[fault_bit] when (vec & mask) == match.
  int fault_mode, fault_bit, fault_mask, fault_match;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  addsub_bist_ctrl #(.WIDTH(4), .SETTLE_CYCLES(1), .ERR_W(16)) u_dut (
    .clk(clk), .rst(rst), .start_i(start),
    .dut_a_o(dut_a), .dut_b_o(dut_b), .dut_sel_o(dut_sel),
    .dut_result_i(dut_result), .dut_overflow_i(dut_overflow),
    .busy_o(busy), .done_o(done), .pass_o(pass), .err_count_o(err_count),
    .fail_vec_o(fail_vec), .fail_valid_o(fail_valid)
  );

  addsub_bist_ctrl #(.WIDTH(4), .SETTLE_CYCLES(1), .ERR_W(8)) u_sat (
    .clk(clk), .rst(rst), .start_i(start),
    .dut_a_o(s_a), .dut_b_o(s_b), .dut_sel_o(s_sel),
    .dut_result_i(s_result), .dut_overflow_i(s_overflow),
    .busy_o(s_busy), .done_o(s_done), .pass_o(s_pass), .err_count_o(s_err_count),
    .fail_vec_o(s_fail_vec), .fail_valid_o(s_fail_valid)
  );

  // Ripple-style adder/subtractor: overflow is carry-into-msb xor carry-out.
  function automatic logic [4:0] adder_model(input logic [3:0] a, input logic [3:0] b,
                                             input logic sel, input int mode, input int fbit,
                                             input int mask, input int match);
    logic [3:0] bx, res, low;
    logic [4:0] full;
    logic [8:0] v;
    logic       ovf;
    bx   = b ^ {4{sel}};
    full = {1'b0, a} + {1'b0, bx} + {4'b0, sel};
    low  = {1'b0, a[2:0]} + {1'b0, bx[2:0]} + {3'b0, sel};
    res  = full[3:0];
    ovf  = full[4] ^ low[3];
    v    = {sel, a, b};
    case (mode)
      1: ovf = 1'b0;
      2: res[0] = 1'b0;
      3: res = ~res;
      4: if ((int'(v) & mask) == match) res[fbit] = ~res[fbit];
      default: ;
    endcase
    return {ovf, res};
  endfunction

  always_comb {dut_overflow, dut_result} =
    adder_model(dut_a, dut_b, dut_sel, fault_mode, fault_bit, fault_mask, fault_match);
  always_comb {s_overflow, s_result} =
    adder_model(s_a, s_b, s_sel, fault_mode, fault_bit, fault_mask, fault_match);

  // Reference: signed integer arithmetic over the first 'limit' vectors,
  // counting those where the faulted adder disagrees with true arithmetic.
  function automatic void ref_sweep(input int mode, input int fbit, input int mask,
                                    input int match, input int limit,
                                    output int cnt, output logic [8:0] first);
    bit any;
    cnt   = 0;
    first = '0;
    any   = 0;
    for (int v = 0; v < limit; v++) begin
      int sel, a, b, sa, sb, t;
      logic [3:0] tres, fres;
      logic tovf, fovf;
      sel  = (v >> 8) & 1;
      a    = (v >> 4) & 15;
      b    = v & 15;
      sa   = (a > 7) ? a - 16 : a;
      sb   = (b > 7) ? b - 16 : b;
      t    = (sel != 0) ? sa - sb : sa + sb;
      tovf = (t > 7) || (t < -8);
      tres = 4'((t + 32) % 16);
      fres = tres;
      fovf = tovf;
      case (mode)
        1: fovf = 1'b0;
        2: fres[0] = 1'b0;
        3: fres = ~tres;
        4: if ((v & mask) == match) fres[fbit] = ~fres[fbit];
        default: ;
      endcase
      if (fres != tres || fovf != tovf) begin
        if (!any) first = 9'(v);
        any = 1;
        cnt++;
      end
    end
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Launch a sweep and wait for done. 'lat' counts rising edges after the
  // accepting edge; done is due after 1 + 512*2 - 1 = 1024 of them, i.e. it
  // is first visible in the 1025th cycle counted from the accept cycle.
  task automatic run_sweep(input string name, input int exp_err, input logic exp_pass,
                           input logic [8:0] exp_first, input int repulse_lat);
    int lat;
    int sat_err;
    sat_err = (exp_err > 255) ? 255 : exp_err;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    check({name, " busy on accept"}, 32'(busy), 32'd1);
    check({name, " vector 0 on accept"}, 32'({dut_sel, dut_a, dut_b}), 32'd0);
    check({name, " err cleared on accept"}, 32'(err_count), 32'd0);
    check({name, " done cleared on accept"}, 32'(done), 32'd0);
    lat = 0;
    while (!done && lat < 1100) begin
      start = (lat == repulse_lat);
      @(posedge clk);
      lat++;
      @(negedge clk);
      if (lat == 201) check({name, " vector 100 held"}, 32'({dut_sel, dut_a, dut_b}), 32'd100);
    end
    start = 1'b0;
    check({name, " done latency"}, 32'(lat), 32'd1024);
    check({name, " busy at done"}, 32'(busy), 32'd0);
    check({name, " err_count"}, 32'(err_count), 32'(exp_err));
    check({name, " pass"}, 32'(pass), 32'(exp_pass));
    check({name, " sat err_count"}, 32'(s_err_count), 32'(sat_err));
    check({name, " sat pass"}, 32'(s_pass & s_done), 32'(exp_err == 0));
`ifdef ADDSUB_BIST_FAIL_CAPTURE_EN
    check({name, " fail_valid"}, 32'(fail_valid), 32'(exp_err != 0));
    check({name, " fail_vec"}, 32'(fail_vec), 32'((exp_err != 0) ? exp_first : 9'd0));
    check({name, " sat fail_vec"}, 32'(s_fail_vec), 32'((exp_err != 0) ? exp_first : 9'd0));
`else
    check({name, " fail_valid tied"}, 32'(fail_valid | s_fail_valid), 32'd0);
    check({name, " fail_vec tied"}, 32'(fail_vec | s_fail_vec), 32'd0);
`endif
  endtask

  typedef struct {
    string      name;
    int         mode;
    int         exp_err;
    logic       exp_pass;
    logic [8:0] exp_first;
  } vec_t;

  vec_t table_v[4];

  initial begin
    int lat, cnt, prefix;
    logic [8:0] first;

    table_v[0] = '{"clean", 0, 0, 1'b1, 9'h000};
    table_v[1] = '{"ovf tied 0", 1, 128, 1'b0, 9'h017};
    table_v[2] = '{"res0 stuck 0", 2, 256, 1'b0, 9'h001};
    table_v[3] = '{"res inverted", 3, 512, 1'b0, 9'h000};

    rst = 1'b1; start = 1'b0;
    fault_mode = 0; fault_bit = 0; fault_mask = 0; fault_match = 0;
    repeat (3) @(negedge clk);
    check("reset busy", 32'(busy), 32'd0);
    check("reset done/pass", 32'({done, pass}), 32'd0);
    check("reset err_count", 32'(err_count), 32'd0);
    check("reset operands", 32'({dut_sel, dut_a, dut_b}), 32'd0);
    check("reset fail capture", 32'({fail_valid, fail_vec}), 32'd0);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    check("idle without start", 32'({busy, done}), 32'd0);

    foreach (table_v[i]) begin
      fault_mode = table_v[i].mode;
      run_sweep(table_v[i].name, table_v[i].exp_err, table_v[i].exp_pass,
                table_v[i].exp_first, -1);
    end

    // DONE with errors; start held high relaunches, is ignored while busy.
    fault_mode = 0;
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("held start relaunch busy", 32'(busy), 32'd1);
    check("held start relaunch err cleared", 32'(err_count), 32'd0);
    lat = 0;
    repeat (2) begin @(posedge clk); lat++; @(negedge clk); end
    check("held start ignored while busy", 32'({dut_sel, dut_a, dut_b}), 32'd1);
    start = 1'b0;
    while (!done && lat < 1100) begin @(posedge clk); lat++; @(negedge clk); end
    check("held start done latency", 32'(lat), 32'd1024);
    check("held start pass", 32'(pass), 32'd1);

    fault_mode = 0;
    run_sweep("repulse at vector 100", 0, 1'b1, 9'h000, 200);

    // Abort at vector 300 with overflow faults active.
    fault_mode = 1;
    ref_sweep(1, 0, 0, 0, 300, prefix, first);
    @(negedge clk); start = 1'b1;
    @(posedge clk);
    @(negedge clk); start = 1'b0;
    lat = 0;
    while (lat < 600) begin @(posedge clk); lat++; @(negedge clk); end
    check("abort err before reset", 32'(err_count), 32'(prefix));
    check("abort busy before reset", 32'(busy), 32'd1);
    rst = 1'b1;
    #1;
    check("abort busy same cycle", 32'(busy), 32'd0);
    check("abort err same cycle", 32'(err_count), 32'd0);
    check("abort operands", 32'({dut_sel, dut_a, dut_b}), 32'd0);
    @(negedge clk); rst = 1'b0;
    repeat (4) @(negedge clk);
    check("abort stays idle", 32'({busy, done, pass}), 32'd0);
    fault_mode = 0;
    run_sweep("clean after abort", 0, 1'b1, 9'h000, -1);

    // Randomised faults checked against the reference model.
    for (int r = 0; r < 3; r++) begin
      fault_mode  = int'($urandom_range(1, 4));
      fault_bit   = int'($urandom_range(0, 3));
      fault_mask  = int'($urandom_range(0, 511));
      fault_match = int'($urandom) & fault_mask;
      ref_sweep(fault_mode, fault_bit, fault_mask, fault_match, 512, cnt, first);
      repeat ($urandom_range(0, 4)) @(negedge clk);
      run_sweep($sformatf("random %0d mode %0d", r, fault_mode), cnt, cnt == 0, first, -1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

endmodule : tb_addsub_bist_ctrl
